key_event: RTL and testbench



---
 rtl/key_event.sv | 165 ++++++++++++++++
 tb/tb_key_event.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_event.sv
// -----------------------------------------------------------------------------
// key_event
//
// Key-event decoder for the clock's user keys. Turns the debounced key level
// into one-cycle event pulses: short press, long press and auto-repeat.
// Runs entirely in the 100 Hz key clock domain.
//
// Optional feature macro: KEY_REPEAT_EN
//   defined   -> auto-repeat pulses are generated while a long press is held
//   undefined -> no repeat counter is built and o_repeat is constant 0
//
// Parameters:
//   LONG_TICKS   - consecutive high samples that qualify a long press (2..2^CNT_W-1)
//   REPEAT_TICKS - high samples between repeat pulses after a long press (1..2^CNT_W-1)
//   CNT_W        - width of the hold and repeat counters
//
// Ports:
//   i_clk100hz    in   100 Hz key clock, all state changes on rising edge
//   i_rst         in   synchronous active-high reset
//   i_key_in      in   debounced key level, 1 = pressed
//   o_short_press out  one-cycle pulse, key released before LONG_TICKS samples
//   o_long_press  out  one-cycle pulse, key held LONG_TICKS samples
//   o_repeat      out  one-cycle pulse every REPEAT_TICKS samples after long press
//   o_key_held    out  level, a press is being tracked (PRESS or LONG)
// -----------------------------------------------------------------------------
module key_event #(
    parameter int LONG_TICKS   = 100,
    parameter int REPEAT_TICKS = 20,
    parameter int CNT_W        = 8
) (
    input  logic i_clk100hz,
    input  logic i_rst,
    input  logic i_key_in,
    output logic o_short_press,
    output logic o_long_press,
    output logic o_repeat,
    output logic o_key_held
);

    typedef enum logic [1:0] {
        WAIT_REL = 2'd0,
        IDLE     = 2'd1,
        PRESS    = 2'd2,
        LONG     = 2'd3
    } state_t;

    // hold_cnt already counts the current press's samples, so the long-press
    // decision is taken when the count shows LONG_TICKS-1 and one more high
    // sample arrives.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_TICKS - 1);

    // Reject parameter sets the counters cannot represent.
    if (LONG_TICKS < 2 || LONG_TICKS > (2 ** CNT_W) - 1 ||
        REPEAT_TICKS < 1 || REPEAT_TICKS > (2 ** CNT_W) - 1) begin : g_param_check
        $error("key_event: LONG_TICKS/REPEAT_TICKS out of range for CNT_W");
    end

    state_t           r_state;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_short_press;
    logic             r_long_press;
    logic             r_key_held;

`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_TICKS - 1);

    logic [CNT_W-1:0] r_rep_cnt;
    logic             r_repeat;
`endif

    // Press-tracking FSM; all outputs are registered alongside the state.
    always_ff @(posedge i_clk100hz) begin
        if (i_rst) begin
            // A key held across reset is parked in WAIT_REL so it never
            // produces an event.
            r_state       <= WAIT_REL;
            r_hold_cnt    <= '0;
            r_short_press <= 1'b0;
            r_long_press  <= 1'b0;
            r_key_held    <= 1'b0;
`ifdef KEY_REPEAT_EN
            r_rep_cnt     <= '0;
            r_repeat      <= 1'b0;
`endif
        end else begin
            // Pulses default low; only one branch below can raise one.
            r_short_press <= 1'b0;
            r_long_press  <= 1'b0;
`ifdef KEY_REPEAT_EN
            r_repeat      <= 1'b0;
`endif
            case (r_state)
                WAIT_REL: begin
                    r_key_held <= 1'b0;
                    if (!i_key_in) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= WAIT_REL;
                    end
                end
                IDLE: begin
                    if (i_key_in) begin
                        r_state    <= PRESS;
                        r_hold_cnt <= CNT_W'(1);
                        r_key_held <= 1'b1;
                    end else begin
                        r_state    <= IDLE;
                        r_key_held <= 1'b0;
                    end
                end
                PRESS: begin
                    if (!i_key_in) begin
                        r_state       <= IDLE;
                        r_short_press <= 1'b1;
                        r_key_held    <= 1'b0;
                    end else if (r_hold_cnt == HOLD_LAST) begin
                        r_state      <= LONG;
                        r_long_press <= 1'b1;
                        r_key_held   <= 1'b1;
`ifdef KEY_REPEAT_EN
                        r_rep_cnt    <= '0;
`endif
                    end else begin
                        r_state    <= PRESS;
                        r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                        r_key_held <= 1'b1;
                    end
                end
                LONG: begin
                    if (!i_key_in) begin
                        r_state    <= IDLE;
                        r_key_held <= 1'b0;
                    end else begin
                        r_state    <= LONG;
                        r_key_held <= 1'b1;
`ifdef KEY_REPEAT_EN
                        // rep_cnt wraps to 0 on each pulse, giving a pulse
                        // every REPEAT_TICKS held samples.
                        if (r_rep_cnt == REP_LAST) begin
                            r_repeat  <= 1'b1;
                            r_rep_cnt <= '0;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + CNT_W'(1);
                        end
`endif
                    end
                end
                default: begin
                    r_state    <= WAIT_REL;
                    r_key_held <= 1'b0;
                end
            endcase
        end
    end

    assign o_short_press = r_short_press;
    assign o_long_press  = r_long_press;
    assign o_key_held    = r_key_held;
`ifdef KEY_REPEAT_EN
    assign o_repeat      = r_repeat;
`else
    assign o_repeat      = 1'b0;
`endif

endmodule

// File: tb/tb_key_event.sv
// -----------------------------------------------------------------------------
// tb_key_event
//
// Scoreboard bench for key_event with default parameters. Stimulus tasks push
// the expected pulse events (kind + edge number) and expected key_held levels
// into queues; a monitor on the falling clock edge pops and compares them
// whenever the DUT shows a pulse or a key_held checkpoint falls due.
// -----------------------------------------------------------------------------
module tb_key_event;

    localparam int LT = 100;
    localparam int RT = 20;

    localparam int K_SHORT = 0;
    localparam int K_LONG  = 1;
    localparam int K_REP   = 2;

    typedef struct {
        int kind;
        int edge_no;
    } ev_t;

    typedef struct {
        int   edge_no;
        logic val;
    } kh_t;

    logic clk;
    logic rst;
    logic key_in;
    logic short_press;
    logic long_press;
    logic rep_pulse;
    logic key_held;

    int   edge_cnt = 0;
    int   tests    = 0;
    int   fails    = 0;
    logic done     = 1'b0;

    ev_t ev_q[$];
    kh_t kh_q[$];

    key_event #(
        .LONG_TICKS   (LT),
        .REPEAT_TICKS (RT),
        .CNT_W        (8)
    ) dut (
        .i_clk100hz    (clk),
        .i_rst         (rst),
        .i_key_in      (key_in),
        .o_short_press (short_press),
        .o_long_press  (long_press),
        .o_repeat      (rep_pulse),
        .o_key_held    (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic void exp_ev(input int e, input int k);
        ev_t x;
        x.kind    = k;
        x.edge_no = e;
        ev_q.push_back(x);
    endfunction

    function automatic void exp_kh(input int e, input logic v);
        kh_t x;
        x.edge_no = e;
        x.val     = v;
        kh_q.push_back(x);
    endfunction

    // Apply one sample; returns just after the edge that sampled it.
    task automatic drive(input logic k, input logic r);
        key_in = k;
        rst    = r;
        @(posedge clk);
        #1;
    endtask

    // n high samples followed by a single low sample, from IDLE.
    task automatic hold(input int n);
        int b;
        b = edge_cnt + 1;
        if (n < LT) begin
            exp_ev(b + n, K_SHORT);
        end else begin
            exp_ev(b + LT - 1, K_LONG);
`ifdef KEY_REPEAT_EN
            for (int k = 1; LT + k * RT <= n; k++) begin
                exp_ev(b + LT - 1 + k * RT, K_REP);
            end
`endif
        end
        for (int i = 0; i < n; i++) exp_kh(b + i, 1'b1);
        exp_kh(b + n, 1'b0);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin : monitor
        int  npulse;
        int  kind;
        ev_t ev;
        kh_t kh;
        npulse = 0;
        kind   = -1;
        if (short_press === 1'b1) begin npulse++; kind = K_SHORT; end
        if (long_press  === 1'b1) begin npulse++; kind = K_LONG;  end
        if (rep_pulse   === 1'b1) begin npulse++; kind = K_REP;   end

        // Expected events whose edge has passed without a pulse.
        while (ev_q.size() > 0 && ev_q[0].edge_no < edge_cnt) begin
            ev = ev_q.pop_front();
            tests++;
            fails++;
            $display("FAIL missing_pulse: kind %0d expected at edge %0d, got no pulse (now edge %0d)",
                     ev.kind, ev.edge_no, edge_cnt);
        end

        if (npulse > 1) begin
            tests++;
            fails++;
            $display("FAIL exclusive_pulse edge %0d: %0d pulses high, want at most 1",
                     edge_cnt, npulse);
        end else if (npulse == 1) begin
            tests++;
            if (ev_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse edge %0d: got kind %0d, want no pulse",
                         edge_cnt, kind);
            end else begin
                ev = ev_q.pop_front();
                if (ev.kind != kind || ev.edge_no != edge_cnt) begin
                    fails++;
                    $display("FAIL pulse edge %0d: got kind %0d, want kind %0d at edge %0d",
                             edge_cnt, kind, ev.kind, ev.edge_no);
                end
            end
        end

        while (kh_q.size() > 0 && kh_q[0].edge_no <= edge_cnt) begin
            kh = kh_q.pop_front();
            tests++;
            if (kh.edge_no != edge_cnt || key_held !== kh.val) begin
                fails++;
                $display("FAIL key_held edge %0d: got %b, want %b (checkpoint edge %0d)",
                         edge_cnt, key_held, kh.val, kh.edge_no);
            end
        end

        if (done) begin
            tests++;
            if (ev_q.size() != 0 || kh_q.size() != 0) begin
                fails++;
                $display("FAIL leftover_expectations: got %0d events and %0d levels pending, want 0",
                         ev_q.size(), kh_q.size());
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    // Stimulus.
    initial begin : stimulus
        int b;
        key_in = 1'b0;
        rst    = 1'b1;

        // Reset state: outputs low after each reset edge.
        exp_kh(1, 1'b0);
        exp_kh(2, 1'b0);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);

        // Basic short press and the single-sample boundary.
        hold(5);
        hold(1);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);

        // Boundary on either side of the long-press threshold.
        hold(99);
        hold(100);
        drive(1'b0, 1'b0);

        // Long hold; repeat pulses only when the feature is built.
        hold(145);
        drive(1'b0, 1'b0);

        // Reset at hold sample 50 with the key kept high for 200 more samples.
        b = edge_cnt + 1;
        for (int i = 0; i < 49; i++) exp_kh(b + i, 1'b1);
        exp_kh(b + 49, 1'b0);
        for (int i = 0; i < 200; i++) exp_kh(b + 50 + i, 1'b0);
        exp_kh(b + 250, 1'b0);
        for (int i = 0; i < 49; i++) drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        for (int i = 0; i < 200; i++) drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        hold(3);
        drive(1'b0, 1'b0);

        // Minimum gap: one low sample between presses.
        hold(3);
        hold(3);
        drive(1'b0, 1'b0);

        // Very long hold.
        hold(300);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);

        done = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL summary_not_reached: monitor did not finish, want finish");
        $fatal(1, "monitor did not finish");
    end

    // Absolute time bound.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, want finish");
        $fatal(1, "watchdog");
    end

endmodule
